sram_arbiter: RTL
=================

# sram_arbiter

Shares the single base SRAM between the instruction-fetch miss path (Icache refill) and the data-memory port (load/store). Each access is sequenced through a fixed-latency SRAM cycle. Data accesses have strict priority. While the data side owns or is requesting the SRAM, the block raises `inst_stop` so the Icache freezes. It sits between the Icache/MEM stage and the SRAM pins.

## Interface
- `ADDR_W`, 20: SRAM word-address width; byte address bits `[ADDR_W+1:2]` map to `sram_addr`.
- `RD_CYCLES`, 2: cycles the SRAM read strobes are held before data is sampled (legal range ≥1).
- `WR_CYCLES`, 2: cycles `sram_we_n` is held low (legal range ≥1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  instruction read request (level, held until `i_valid` or abort).
- `i_addr`  in  32  instruction byte address.
- `i_abort`  in  1  branch flush; discards the pending or in-flight instruction read.
- `i_rdata`  out  32  instruction word.
- `i_valid`  out  1  one-cycle pulse, `i_rdata` valid.
- `inst_stop`  out  1  data side owns or wants the SRAM; Icache must not fetch.
- `d_req`  in  1  data request (level, held until `d_done`).
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  write data.
- `d_be`  in  4  byte enables, active-high.
- `d_rdata`  out  32  read data.
- `d_done`  out  1  one-cycle pulse: read data valid, or write complete.
- `sram_addr`  out  ADDR_W  SRAM word address.
- `sram_dq_o`  out  32  write data to pad.
- `sram_dq_oe`  out  1  pad output enable.
- `sram_dq_i`  in  32  read data from pad.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  SRAM strobes, active-low.
- `sram_be_n`  out  4  SRAM byte enables, active-low.

## Operation
- States:
  - IDLE.
  - I_RD: instruction read.
  - D_RD: data read.
  - W_SETUP, W_PULSE, W_HOLD: data write.
- One down-counter `cnt` sized for max(RD_CYCLES, WR_CYCLES).
- Arbitration happens only in IDLE:
  - If `d_req` is high: go to D_RD when `d_we`=0, W_SETUP when `d_we`=1.
  - Else, if `i_req` is high and `i_abort` is low: go to I_RD.
  - Else stay in IDLE.
- Address, write data and byte enables are latched at grant and held for the whole access.
- I_RD and D_RD:
  - Strobes: `ce_n`=0, `oe_n`=0, `we_n`=1, `be_n`=0000, `dq_oe`=0.
  - The access lasts RD_CYCLES cycles.
  - `sram_dq_i` is registered on the last cycle, then the state returns to IDLE.
- Write sequence:
  - W_SETUP: 1 cycle, `ce_n`=0, `we_n`=1, `dq_oe`=1, `be_n`=~d_be.
  - W_PULSE: WR_CYCLES cycles, `we_n`=0.
  - W_HOLD: 1 cycle, `we_n`=1, data still driven; then IDLE.
- `inst_stop` is combinational: `d_req` OR state ∈ {D_RD, W_*}.
- Abort:
  - `i_abort` in any cycle of I_RD sets a kill flag.
  - The SRAM cycle still completes, to keep strobe timing clean.
  - `i_valid` is suppressed and the kill flag clears on return to IDLE.
- A data request that arrives during I_RD waits for I_RD to finish. It is then granted in the following IDLE cycle, before any new instruction request.
- Back-to-back grants are allowed: IDLE lasts exactly one cycle between accesses.
- Reset values (rst=0, effective asynchronously):
  - State IDLE, `cnt`=0, kill flag cleared.
  - `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1, `sram_be_n`=4'hF, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0.
  - `i_valid`=`d_done`=0, `i_rdata`=`d_rdata`=0.
  - `inst_stop` reflects `d_req` only.
- Reset mid-access aborts the access immediately. No `done`/`valid` pulse is generated.

## Timing
- Instruction read:
  - Grant at edge T0.
  - Strobes active during cycles T0..T0+RD_CYCLES-1.
  - `i_valid` and `i_rdata` registered, high for cycle T0+RD_CYCLES.
  - Default latency: req→valid = 3 cycles, including the IDLE cycle.
- Data read: same timing as instruction read, with `d_done` and `d_rdata`.
- Data write:
  - Total occupancy is WR_CYCLES+2 cycles.
  - `d_done` pulses in the cycle after W_HOLD.
- `i_valid` and `d_done` are never high in the same cycle.
- A requester must drop its request in the cycle its valid/done is seen. A request still high afterwards is treated as a new request.
- `inst_stop` rises in the same cycle `d_req` rises. It falls in the cycle after the data access leaves its final state, provided `d_req` is low.

## Test plan
- Isolated instruction fetch:
  - Stimulus: `i_addr`=0x8000_0010, SRAM model returns 0x2408_0001.
  - Required: `sram_addr`=0x00004, `i_valid` high 3 cycles after `i_req`, `i_rdata`=0x2408_0001.
- Simultaneous requests:
  - Stimulus: `i_req` and `d_req` (read, 0x8000_0100) rise together.
  - Required: data served first, `inst_stop`=1 throughout, `d_done` before `i_valid`. The instruction is granted in the IDLE cycle after `d_done`.
- Byte write:
  - Stimulus: `d_be`=4'b0010, `d_wdata`=0x0000_AB00.
  - Required: `be_n`=4'b1101, `we_n` low exactly 2 cycles, `dq_oe` high for 4 cycles, `d_done` once.
- Abort:
  - Stimulus: `i_abort` during the second cycle of I_RD.
  - Required: strobes complete normally, no `i_valid`, next `i_req` is serviced normally.
- Data request arriving mid instruction read:
  - Stimulus: `d_req` rises in cycle 1 of I_RD.
  - Required: `inst_stop`=1 immediately, I_RD finishes with `i_valid`, D_RD starts after one IDLE cycle.
- Asynchronous reset:
  - Stimulus: rst=0 asserted mid W_PULSE.
  - Required: `we_n`/`ce_n` go high and `dq_oe` goes low without waiting for a clock edge, no `d_done`. After release the state is IDLE.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between Icache refill and
// the data port, with data-side priority and an Icache freeze signal.
module sram_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    input  logic              i_abort,
    output logic [31:0]       i_rdata,
    output logic              i_valid,
    output logic              inst_stop,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE, I_RD, D_RD, W_SETUP, W_PULSE, W_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              i_valid_q, i_valid_d;
    logic              d_done_q, d_done_d;
    logic              last;

    // Address bits outside the word address are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    assign last = (cnt_q == '0);

    // Arbitration, access sequencing and result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kill_d    = kill_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_valid_d = 1'b0;
        d_done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (d_req) begin
                    addr_d  = d_addr[ADDR_W+1:2];
                    wdata_d = d_wdata;
                    be_d    = d_be;
                    cnt_d   = CW'(RD_CYCLES - 1);
                    state_d = d_we ? W_SETUP : D_RD;
                end else if (i_req && !i_abort) begin
                    addr_d  = i_addr[ADDR_W+1:2];
                    cnt_d   = CW'(RD_CYCLES - 1);
                    state_d = I_RD;
                end
            end
            I_RD: begin
                if (i_abort) kill_d = 1'b1;
                if (last) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    if (!kill_q && !i_abort) begin
                        i_valid_d = 1'b1;
                        i_rdata_d = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            D_RD: begin
                if (last) begin
                    state_d   = IDLE;
                    d_done_d  = 1'b1;
                    d_rdata_d = sram_dq_i;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            W_SETUP: begin
                cnt_d   = CW'(WR_CYCLES - 1);
                state_d = W_PULSE;
            end
            W_PULSE: begin
                if (last) state_d = W_HOLD;
                else      cnt_d   = cnt_q - CW'(1);
            end
            W_HOLD: begin
                state_d  = IDLE;
                d_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any access at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            kill_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_valid_q <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kill_q    <= kill_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_valid_q <= i_valid_d;
            d_done_q  <= d_done_d;
        end
    end

    // SRAM strobes decoded from the current state.
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_be_n  = 4'hF;
        sram_dq_oe = 1'b0;
        unique case (state_q)
            I_RD, D_RD: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_be_n = 4'h0;
            end
            W_SETUP, W_HOLD: begin
                sram_ce_n  = 1'b0;
                sram_be_n  = ~be_q;
                sram_dq_oe = 1'b1;
            end
            W_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_be_n  = ~be_q;
                sram_dq_oe = 1'b1;
            end
            default: ;
        endcase
    end

    assign inst_stop = d_req || (state_q == D_RD) || (state_q == W_SETUP)
                    || (state_q == W_PULSE) || (state_q == W_HOLD);
    assign sram_addr = addr_q;
    assign sram_dq_o = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_valid   = i_valid_q;
    assign d_done    = d_done_q;

endmodule
